// File: rtl/gray2rgb_pkg.sv
// Shared types and constants for the grayscale-to-RGB Avalon-ST expander.
// Optional length checking is enabled by defining GRAY2RGB_LENGTH_CHECK_EN.
package gray2rgb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PACKET = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] gray;
        logic       sop;
        logic       eop;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    function automatic logic [23:0] expand_gray(input logic [7:0] gray);
        logic [23:0] rgb;
        rgb               = '0;
        rgb[R_LSB +: 8]   = gray;
        rgb[G_LSB +: 8]   = gray;
        rgb[B_LSB +: 8]   = gray;
        return rgb;
    endfunction

endpackage

// File: rtl/avalon_st_skid_buffer.sv
// Generic 2-entry Avalon-ST skid buffer: output register plus one overflow
// register, with sink_ready driven straight from a flop.
module avalon_st_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sink_data,
    input  logic             sink_valid,
    output logic             sink_ready,
    output logic [WIDTH-1:0] source_data,
    output logic             source_valid,
    input  logic             source_ready
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] ovf_q;
    logic             out_valid_q;
    logic             ovf_valid_q;
    logic             ready_q;
    logic             sink_xfer;
    logic             out_free;
    logic             ovf_valid_d;

    assign sink_xfer = sink_valid & ready_q;
    assign out_free  = ~out_valid_q | source_ready;

    // The overflow entry only fills when the output register is held by a stall.
    always_comb begin
        ovf_valid_d = out_free ? 1'b0 : (ovf_valid_q | sink_xfer);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset too, so the source bus reads 0 during reset.
            out_q       <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            if (out_free) begin
                if (ovf_valid_q) begin
                    out_q       <= ovf_q;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= sink_xfer;
                    if (sink_xfer) out_q <= sink_data;
                end
            end else if (sink_xfer) begin
                ovf_q <= sink_data;
            end
            ovf_valid_q <= ovf_valid_d;
            ready_q     <= ~ovf_valid_d;
        end
    end

    assign sink_ready   = ready_q;
    assign source_data  = out_q;
    assign source_valid = out_valid_q;

endmodule

// File: rtl/gray2rgb_avalon_streaming.sv
// Avalon-ST 8-bit gray to 24-bit RGB expander with framing enforcement and
// sticky errors; GRAY2RGB_LENGTH_CHECK_EN adds the packet-length check.
module gray2rgb_avalon_streaming
    import gray2rgb_pkg::*;
#(
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19
) (
    input  logic        csi_clock_reset_clk,
    input  logic        csi_clock_reset_reset,
    input  logic [7:0]  asi_sink1_data,
    input  logic        asi_sink1_startofpacket,
    input  logic        asi_sink1_endofpacket,
    input  logic        asi_sink1_valid,
    output logic        asi_sink1_ready,
    input  logic        aso_source1_ready,
    output logic [23:0] aso_source1_data,
    output logic        aso_source1_startofpacket,
    output logic        aso_source1_endofpacket,
    output logic        aso_source1_valid,
    input  logic        coe_error_clear,
    output logic        coe_framing_error,
    output logic        coe_length_error,
    output logic        coe_frame_done
);

    if ((64'd1 << CNT_W) <= 64'(FRAME_PIXELS)) begin : g_cnt_w_check
        $error("CNT_W is too narrow to count FRAME_PIXELS");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sink_xfer;
    logic             fwd;
    logic             framing_set;
    logic             framing_q;
    beat_t            sink_beat;
    beat_t            src_beat;

    assign sink_xfer = asi_sink1_valid & asi_sink1_ready;
    // In a packet every beat goes through; outside one only an SOP may start a new one.
    assign fwd       = (state_q == ST_PACKET) | asi_sink1_startofpacket;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        framing_set = 1'b0;
        if (sink_xfer) begin
            if (asi_sink1_startofpacket) begin
                framing_set = (state_q == ST_PACKET);
                cnt_d       = CNT_W'(1);
                state_d     = asi_sink1_endofpacket ? ST_IDLE : ST_PACKET;
            end else if (state_q == ST_PACKET) begin
                cnt_d   = cnt_inc;
                state_d = asi_sink1_endofpacket ? ST_IDLE : ST_PACKET;
            end else begin
                framing_set = 1'b1;
            end
        end
    end

    always_ff @(posedge csi_clock_reset_clk or posedge csi_clock_reset_reset) begin
        if (csi_clock_reset_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            framing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            framing_q <= framing_set | (framing_q & ~coe_error_clear);
        end
    end

`ifdef GRAY2RGB_LENGTH_CHECK_EN
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
    logic length_set;
    logic length_q;

    // cnt_d already includes the beat being accepted; an in-packet SOP truncates the old packet.
    always_comb begin
        length_set = 1'b0;
        if (sink_xfer) begin
            if (state_q == ST_PACKET && asi_sink1_startofpacket)
                length_set = 1'b1;
            else if (fwd && asi_sink1_endofpacket)
                length_set = (cnt_d != FRAME_CNT);
        end
    end

    always_ff @(posedge csi_clock_reset_clk or posedge csi_clock_reset_reset) begin
        if (csi_clock_reset_reset) length_q <= 1'b0;
        else                       length_q <= length_set | (length_q & ~coe_error_clear);
    end

    assign coe_length_error = length_q;
`else
    assign coe_length_error = 1'b0;
`endif

    assign sink_beat = '{gray: asi_sink1_data,
                         sop:  asi_sink1_startofpacket,
                         eop:  asi_sink1_endofpacket};

    avalon_st_skid_buffer #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk          (csi_clock_reset_clk),
        .rst          (csi_clock_reset_reset),
        .sink_data    (sink_beat),
        .sink_valid   (asi_sink1_valid & fwd),
        .sink_ready   (asi_sink1_ready),
        .source_data  (src_beat),
        .source_valid (aso_source1_valid),
        .source_ready (aso_source1_ready)
    );

    assign aso_source1_data          = expand_gray(src_beat.gray);
    assign aso_source1_startofpacket = src_beat.sop;
    assign aso_source1_endofpacket   = src_beat.eop;
    assign coe_framing_error         = framing_q;
    assign coe_frame_done            = aso_source1_valid & aso_source1_ready & src_beat.eop;

endmodule
